// File: rtl/scr1_ahb_mem_slave.sv
// AHB-Lite memory responder: terminates single transfers into a local
// word-organised array with optional wait states and a two-cycle ERROR response.
module scr1_ahb_mem_slave #(
  parameter int unsigned SCR1_MEM_DEPTH   = 1024,
  parameter logic [31:0] SCR1_MEM_BASE    = 32'h0000_0000,
  parameter int unsigned SCR1_WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int unsigned AW      = $clog2(SCR1_MEM_DEPTH);
  localparam logic [2:0]  WS_LOAD = (SCR1_WAIT_STATES > 0) ? 3'(SCR1_WAIT_STATES - 1) : 3'd0;
  localparam logic [32:0] ADDR_LO = {1'b0, SCR1_MEM_BASE};
  localparam logic [32:0] ADDR_HI = ADDR_LO + (33'(SCR1_MEM_DEPTH) << 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  logic [31:0]   mem [SCR1_MEM_DEPTH];
  state_t        state, state_next;
  logic [2:0]    wait_cnt, wait_cnt_next;
  logic          wr_q;
  logic [AW-1:0] widx_q;
  logic [3:0]    mask_q;
  logic [31:0]   rd_q;

  logic          accept;
  logic          addr_err;
  logic [3:0]    mask_a;
  logic [AW-1:0] idx_a;
  logic          commit;
  logic [31:0]   wmask32;
  logic [31:0]   mem_rd;
  logic [31:0]   fwd_rd;
  logic          unused_bus;

  assign unused_bus = ^{hburst, hprot, htrans[0]};

  // A new address phase is only taken in cycles where the bus is completing.
  assign accept = hsel & hready_in & htrans[1] &
                  ((state == ST_IDLE) | (state == ST_DATA) | (state == ST_ERR2));
  assign idx_a  = haddr[AW+1:2];
  assign commit = (state == ST_DATA) & wr_q;

  // Address-phase decode: byte lanes and error classification.
  always_comb begin
    mask_a   = '0;
    addr_err = 1'b0;
    case (hsize)
      3'd0: mask_a = 4'b0001 << haddr[1:0];
      3'd1: begin
        mask_a   = haddr[1] ? 4'b1100 : 4'b0011;
        addr_err = haddr[0];
      end
      3'd2: begin
        mask_a   = 4'b1111;
        addr_err = |haddr[1:0];
      end
      default: addr_err = 1'b1;
    endcase
    if (({1'b0, haddr} < ADDR_LO) || ({1'b0, haddr} >= ADDR_HI))
      addr_err = 1'b1;
  end

  // Read word for the incoming address, merged with a write committing at the
  // same edge. Reads sitting in WAIT cannot overlap a commit since only one
  // transfer is ever in its data phase, so this same-edge merge is sufficient.
  always_comb begin
    wmask32 = {{8{mask_q[3]}}, {8{mask_q[2]}}, {8{mask_q[1]}}, {8{mask_q[0]}}};
    mem_rd  = mem[idx_a];
    fwd_rd  = mem_rd;
    if (commit && (widx_q == idx_a))
      fwd_rd = (mem_rd & ~wmask32) | (hwdata & wmask32);
  end

  // Next-state logic for the data-phase sequencer.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept) begin
          if (addr_err) begin
            state_next = ST_ERR1;
          end else if (SCR1_WAIT_STATES != 0) begin
            state_next    = ST_WAIT;
            wait_cnt_next = WS_LOAD;
          end else begin
            state_next = ST_DATA;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 3'd0) state_next = ST_DATA;
        else                  wait_cnt_next = wait_cnt - 3'd1;
      end
      ST_ERR1: state_next = ST_ERR2;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      hreadyout <= !((state_next == ST_WAIT) || (state_next == ST_ERR1));
      hresp     <= (state_next == ST_ERR1) || (state_next == ST_ERR2);
    end
  end

  // Capture of the accepted transfer's attributes and read word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= 1'b0;
      widx_q <= '0;
      mask_q <= '0;
      rd_q   <= '0;
    end else if (accept) begin
      wr_q   <= hwrite;
      widx_q <= idx_a;
      mask_q <= mask_a;
      rd_q   <= (hwrite || addr_err) ? '0 : fwd_rd;
    end
  end

  // Byte-masked write commit at the end of the final data-phase cycle.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (mask_q[b]) mem[widx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hrdata = ((state == ST_DATA) && !wr_q) ? rd_q : '0;

endmodule

// File: tb/tb_scr1_ahb_mem_slave.sv
// Directed bench for scr1_ahb_mem_slave: three instances (0, 3 and 2 wait
// states) share the address/data bus; sel chooses which one is addressed.
module tb_scr1_ahb_mem_slave;

  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] haddr;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        force_hri_low;
  logic [1:0]  sel;

  logic        hsel0, hsel3, hsel2;
  logic        hri0, hri3, hri2;
  logic        hro0, hro3, hro2;
  logic        hresp0, hresp3, hresp2;
  logic [31:0] hrd0, hrd3, hrd2;
  logic        hro, hresp_m;
  logic [31:0] hrdata_m;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign hsel0 = hsel && (sel == 2'd0);
  assign hsel3 = hsel && (sel == 2'd1);
  assign hsel2 = hsel && (sel == 2'd2);
  assign hri0  = hro0 & ~force_hri_low;
  assign hri3  = hro3 & ~force_hri_low;
  assign hri2  = hro2 & ~force_hri_low;

  assign hro      = (sel == 2'd0) ? hro0   : (sel == 2'd1) ? hro3   : hro2;
  assign hresp_m  = (sel == 2'd0) ? hresp0 : (sel == 2'd1) ? hresp3 : hresp2;
  assign hrdata_m = (sel == 2'd0) ? hrd0   : (sel == 2'd1) ? hrd3   : hrd2;

  scr1_ahb_mem_slave #(.SCR1_MEM_DEPTH(DEPTH), .SCR1_MEM_BASE(32'h0), .SCR1_WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel0), .htrans(htrans), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata), .hready_in(hri0),
    .hreadyout(hro0), .hresp(hresp0), .hrdata(hrd0));

  scr1_ahb_mem_slave #(.SCR1_MEM_DEPTH(DEPTH), .SCR1_MEM_BASE(32'h0), .SCR1_WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel3), .htrans(htrans), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata), .hready_in(hri3),
    .hreadyout(hro3), .hresp(hresp3), .hrdata(hrd3));

  scr1_ahb_mem_slave #(.SCR1_MEM_DEPTH(DEPTH), .SCR1_MEM_BASE(32'h0), .SCR1_WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel2), .htrans(htrans), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata), .hready_in(hri2),
    .hreadyout(hro2), .hresp(hresp2), .hrdata(hrd2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic addr_ph(input logic w, input logic [2:0] sz, input logic [31:0] a);
    hsel = 1'b1; htrans = 2'b10; hwrite = w; hsize = sz; haddr = a;
  endtask

  task automatic idle_ph();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h0;
  endtask

  // Runs one data phase; returns wait cycles, hresp seen while stalled, final hresp/hrdata.
  task automatic data_ph(input logic [31:0] wd, output int waits, output logic resp_lo,
                         output logic resp, output logic [31:0] rd);
    logic done;
    hwdata = wd; waits = 0; resp_lo = 1'b0; resp = 1'b0; rd = '0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (hro === 1'b1) begin
        resp = hresp_m; rd = hrdata_m; done = 1'b1;
      end else begin
        waits++; resp_lo = hresp_m;
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      vectors++; miscompares++;
      $error("FAIL data_phase_timeout: observed hreadyout stuck low, expected high within 20 cycles");
    end
  endtask

  task automatic single(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        output int waits, output logic resp_lo, output logic resp, output logic [31:0] rd);
    @(posedge clk); #1;
    addr_ph(w, sz, a);
    @(posedge clk); #1;
    idle_ph();
    data_ph(wd, waits, resp_lo, resp, rd);
  endtask

  // Write then read of 0x40 with the read address phase overlapping the write data phase.
  task automatic wr_then_rd(input logic [2:0] wsz, input logic [31:0] wa, input logic [31:0] wd,
                            output int wwaits, output int rwaits, output logic [31:0] rd);
    logic rl, rr;
    logic [31:0] dummy;
    @(posedge clk); #1;
    addr_ph(1'b1, wsz, wa);
    @(posedge clk); #1;
    addr_ph(1'b0, 3'd2, 32'h40);
    data_ph(wd, wwaits, rl, rr, dummy);
    @(posedge clk); #1;
    idle_ph();
    data_ph(32'h0, rwaits, rl, rr, rd);
  endtask

  task automatic gate(input logic s, input logic [1:0] tr, input logic frc, input string tag);
    @(posedge clk); #1;
    hsel = s; htrans = tr; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h50; force_hri_low = frc;
    @(posedge clk); #1;
    idle_ph(); force_hri_low = 1'b0; hwdata = 32'h0;
    @(negedge clk);
    check({tag, "_hreadyout"}, 32'(hro), 32'd1);
    check({tag, "_hresp"}, 32'(hresp_m), 32'd0);
  endtask

  initial begin
    int w, w2;
    logic rl, rr;
    logic [31:0] rd;

    hburst = 3'b000; hprot = 4'b0011; hwdata = '0; force_hri_low = 1'b0; sel = 2'd0;
    idle_ph();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_hreadyout", 32'(hro), 32'd1);
    check("reset_hresp", 32'(hresp_m), 32'd0);
    check("reset_hrdata", hrdata_m, 32'h0);

    // Zero-wait word write / read.
    single(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, w, rl, rr, rd);
    check("ws0_write_waits", 32'(w), 32'd0);
    check("ws0_write_resp", 32'(rr), 32'd0);
    single(1'b0, 3'd2, 32'h10, 32'h0, w, rl, rr, rd);
    check("ws0_read_waits", 32'(w), 32'd0);
    check("ws0_read_resp", 32'(rr), 32'd0);
    check("ws0_read_data", rd, 32'hDEADBEEF);

    // Byte and halfword lanes; junk in unselected lanes must not land.
    single(1'b1, 3'd2, 32'h20, 32'h0000_0000, w, rl, rr, rd);
    single(1'b1, 3'd0, 32'h23, 32'hAA5A_5A5A, w, rl, rr, rd);
    single(1'b1, 3'd1, 32'h20, 32'h7777_1234, w, rl, rr, rd);
    single(1'b0, 3'd2, 32'h20, 32'h0, w, rl, rr, rd);
    check("sub_word_merge", rd, 32'hAA001234);

    // Pipelined write->read forwarding, zero wait.
    single(1'b1, 3'd2, 32'h40, 32'hFFFF_FFFF, w, rl, rr, rd);
    wr_then_rd(3'd2, 32'h40, 32'h1122_3344, w, w2, rd);
    check("ws0_fwd_wwaits", 32'(w), 32'd0);
    check("ws0_fwd_rwaits", 32'(w2), 32'd0);
    check("ws0_fwd_data", rd, 32'h1122_3344);
    wr_then_rd(3'd1, 32'h42, 32'hBEEF_0000, w, w2, rd);
    check("ws0_fwd_half_merge", rd, 32'hBEEF_3344);

    // Same sequence with three wait states.
    sel = 2'd1;
    single(1'b1, 3'd2, 32'h40, 32'hFFFF_FFFF, w, rl, rr, rd);
    wr_then_rd(3'd2, 32'h40, 32'h1122_3344, w, w2, rd);
    check("ws3_fwd_wwaits", 32'(w), 32'd3);
    check("ws3_fwd_rwaits", 32'(w2), 32'd3);
    check("ws3_fwd_data", rd, 32'h1122_3344);
    single(1'b0, 3'd1, 32'h21, 32'h0, w, rl, rr, rd);
    check("ws3_err_waits", 32'(w), 32'd1);
    check("ws3_err_resp", 32'(rr), 32'd1);

    // Error responses on the zero-wait instance.
    sel = 2'd0;
    single(1'b0, 3'd2, 32'h42, 32'h0, w, rl, rr, rd);
    check("misalign_err1_cycles", 32'(w), 32'd1);
    check("misalign_err1_resp", 32'(rl), 32'd1);
    check("misalign_err2_resp", 32'(rr), 32'd1);
    check("misalign_hrdata", rd, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_err_hreadyout", 32'(hro), 32'd1);
    check("post_err_hresp", 32'(hresp_m), 32'd0);
    single(1'b0, 3'd3, 32'h20, 32'h0, w, rl, rr, rd);
    check("bad_size_resp", 32'(rr), 32'd1);
    single(1'b1, 3'd2, 32'h0, 32'h5555_AAAA, w, rl, rr, rd);
    single(1'b1, 3'd2, 32'h100, 32'hFFFF_FFFF, w, rl, rr, rd);
    check("oor_write_cycles", 32'(w), 32'd1);
    check("oor_write_resp", 32'(rr), 32'd1);
    single(1'b0, 3'd2, 32'h0, 32'h0, w, rl, rr, rd);
    check("oor_word0_intact", rd, 32'h5555_AAAA);

    // Gating: none of these may be taken as a transfer.
    single(1'b1, 3'd2, 32'h50, 32'hCAFE_F00D, w, rl, rr, rd);
    gate(1'b1, 2'b01, 1'b0, "busy");
    gate(1'b1, 2'b00, 1'b0, "idle");
    gate(1'b0, 2'b10, 1'b0, "nosel");
    gate(1'b1, 2'b10, 1'b1, "hready_low");
    single(1'b0, 3'd2, 32'h50, 32'h0, w, rl, rr, rd);
    check("gating_mem_intact", rd, 32'hCAFE_F00D);

    // Reset during the wait phase of a write drops it.
    sel = 2'd2;
    single(1'b1, 3'd2, 32'h80, 32'h0102_0304, w, rl, rr, rd);
    check("ws2_write_waits", 32'(w), 32'd2);
    @(posedge clk); #1;
    addr_ph(1'b1, 3'd2, 32'h80);
    @(posedge clk); #1;
    idle_ph(); hwdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("ws2_in_wait", 32'(hro), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_hreadyout", 32'(hro), 32'd1);
    check("rst_mid_hresp", 32'(hresp_m), 32'd0);
    check("rst_mid_hrdata", hrdata_m, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    single(1'b0, 3'd2, 32'h80, 32'h0, w, rl, rr, rd);
    check("rst_read_waits", 32'(w), 32'd2);
    check("rst_write_lost", rd, 32'h0102_0304);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
